pe_act_broadcast: RTL and testbench



---
 rtl/pe_act_broadcast_if.sv | 38 +++
 rtl/pe_act_broadcast.sv | 185 ++++++++++++++++++
 tb/tb_pe_act_broadcast.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_act_broadcast_if.sv
// Bus bundle for the activation broadcast transmitter: register-file read
// port toward the activation register file and the valid/ready packet
// stream toward the broadcast network.
interface pe_act_broadcast_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ACT_NO_W = 6,
    parameter int unsigned PE_IDX_W = 6
);
    logic                                 rf_rd_en;
    logic                                 rf_rd_bank;
    logic [ACT_NO_W-1:0]                  rf_rd_addr;
    logic [DATA_W-1:0]                    rf_rd_data;
    logic                                 bc_valid;
    logic                                 bc_ready;
    logic [ACT_NO_W+PE_IDX_W+DATA_W-1:0]  bc_data;

    // Transmitter side.
    modport master (
        output rf_rd_en,
        output rf_rd_bank,
        output rf_rd_addr,
        input  rf_rd_data,
        output bc_valid,
        output bc_data,
        input  bc_ready
    );

    // Register file / network side.
    modport slave (
        input  rf_rd_en,
        input  rf_rd_bank,
        input  rf_rd_addr,
        output rf_rd_data,
        input  bc_valid,
        input  bc_data,
        output bc_ready
    );
endinterface

// File: rtl/pe_act_broadcast.sv
// Per-PE activation broadcast transmitter. On start it scans the local
// activations, drops zeros (optionally), tags survivors with their absolute
// index {local addr, PE_IDX} and streams them out in ascending address order,
// then pulses fin_broadcast once the last packet has been accepted.
module pe_act_broadcast #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ACT_NO_W   = 6,
    parameter int unsigned PE_IDX_W   = 6,
    parameter bit          SKIP_ZERO  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PE_IDX_W-1:0] PE_IDX,
    input  logic                start_broadcast,
    input  logic [ACT_NO_W:0]   in_act_no,
    input  logic                act_regfile_dir,
    pe_act_broadcast_if.master  bus,
    output logic                busy,
    output logic                fin_broadcast
);

    localparam int unsigned PKT_W = ACT_NO_W + PE_IDX_W + DATA_W;
    localparam int unsigned AW    = ACT_NO_W + 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     n_q, n_d;
    logic              bank_q, bank_d;
    // One bit wider than the local address so n == 2^ACT_NO_W terminates.
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    // Read tag pipeline: the read data arrives one cycle after issue.
    logic              rd_pend_q, rd_pend_d;
    logic [ACT_NO_W-1:0] rd_tag_q, rd_tag_d;
    logic              fin_q, fin_d;

    logic [PKT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;

    logic              issue;
    logic              clear;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic              done;
    logic [SUM_W-1:0]  credit_used;

    // Credit and completion terms; a same-cycle pop is deliberately not credited.
    always_comb begin
        credit_used = SUM_W'(occ_q) + SUM_W'(rd_pend_q);
        credit_ok   = credit_used < SUM_W'(FIFO_DEPTH);
        done        = (rd_addr_q == n_q) && !rd_pend_q && (occ_q == '0);
    end

    // FSM next state, read issue and run-parameter capture.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        bank_d    = bank_q;
        rd_addr_d = rd_addr_q;
        rd_pend_d = 1'b0;
        rd_tag_d  = rd_tag_q;
        fin_d     = 1'b0;
        issue     = 1'b0;
        clear     = 1'b0;
        case (state_q)
            StIdle: begin
                // A start landing on the fin cycle is dropped, not queued.
                if (start_broadcast && !fin_q) begin
                    state_d   = StRun;
                    n_d       = in_act_no;
                    bank_d    = act_regfile_dir;
                    rd_addr_d = '0;
                    clear     = 1'b1;
                end
            end
            StRun: begin
                if (done) begin
                    state_d = StIdle;
                    fin_d   = 1'b1;
                end else if ((rd_addr_q < n_q) && credit_ok) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                    rd_pend_d = 1'b1;
                    rd_tag_d  = rd_addr_q[ACT_NO_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            bank_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            bank_q    <= bank_d;
            rd_addr_q <= rd_addr_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
            fin_q     <= fin_d;
        end
    end

    // Returning read data: keep nonzero (or all) entries, zeros just free their credit.
    always_comb begin
        push = rd_pend_q && !(SKIP_ZERO && (bus.rf_rd_data == '0));
        pop  = bus.bc_valid && bus.bc_ready;
    end

    // Output buffer pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output buffer storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {rd_tag_q, PE_IDX, bus.rf_rd_data};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Outputs; read port fields are zero when no read is issued.
    always_comb begin
        bus.rf_rd_en   = issue;
        bus.rf_rd_bank = issue & bank_q;
        bus.rf_rd_addr = issue ? rd_addr_q[ACT_NO_W-1:0] : '0;
        bus.bc_valid   = (occ_q != '0);
        bus.bc_data    = bus.bc_valid ? mem_q[rd_ptr_q] : '0;
        busy           = (state_q == StRun) || fin_q;
        fin_broadcast  = fin_q;
    end

    // Credit scheme guarantees a free slot for every returning read.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && (occ_q == CNT_W'(FIFO_DEPTH))));

    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (bus.bc_valid && !bus.bc_ready) |=> (bus.bc_valid && $stable(bus.bc_data)));

    a_fin_pulse : assert property (@(posedge clk) disable iff (rst)
        fin_q |=> !fin_q);

endmodule

// File: tb/tb_pe_act_broadcast.sv
// Scoreboard bench for pe_act_broadcast: the expected packet list is built
// from the register-file contents at start time; a monitor pops and compares
// on every handshake and checks read ordering, credits, stalls and fin timing.
module tb_pe_act_broadcast;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACT_NO_W   = 6;
    localparam int unsigned PE_IDX_W   = 6;
    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned NENT       = 1 << ACT_NO_W;
    localparam int unsigned PKT_W      = ACT_NO_W + PE_IDX_W + DATA_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [PE_IDX_W-1:0] pe_idx;
    logic                start_broadcast;
    logic [ACT_NO_W:0]   in_act_no;
    logic                act_regfile_dir;
    logic                busy;
    logic                fin_broadcast;

    pe_act_broadcast_if #(
        .DATA_W  (DATA_W),
        .ACT_NO_W(ACT_NO_W),
        .PE_IDX_W(PE_IDX_W)
    ) bus ();

    pe_act_broadcast #(
        .DATA_W    (DATA_W),
        .ACT_NO_W  (ACT_NO_W),
        .PE_IDX_W  (PE_IDX_W),
        .SKIP_ZERO (1'b1),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PE_IDX         (pe_idx),
        .start_broadcast(start_broadcast),
        .in_act_no      (in_act_no),
        .act_regfile_dir(act_regfile_dir),
        .bus            (bus),
        .busy           (busy),
        .fin_broadcast  (fin_broadcast)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: two banks, data valid one cycle after the read.
    logic [DATA_W-1:0] rf_mem [2][NENT];
    always @(posedge clk) begin
        if (bus.rf_rd_en) bus.rf_rd_data <= rf_mem[bus.rf_rd_bank][bus.rf_rd_addr];
        else              bus.rf_rd_data <= DATA_W'($urandom);
    end

    // Network ready: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    initial begin
        bus.bc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.bc_ready = 1'b1;
                1:       bus.bc_ready = 1'($urandom_range(0, 1));
                default: bus.bc_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard and per-run bookkeeping.
    logic [PKT_W-1:0] exp_q [$];
    int   run_n = 0;
    logic run_bank = 1'b0;
    int   rd_idx = 0, rd_cnt = 0, hs_cnt = 0, disc_cnt = 0;
    int   fin_cnt = 0, fin_cyc = -1, start_cyc = 0, last_evt = 0;
    int   first_rd = -1, first_valid = -1;
    bit   chk_b2b = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Monitor: everything sampled on the falling edge.
    initial begin
        bit               rd_last = 1'b0;
        bit               prev_stall = 1'b0;
        logic [PKT_W-1:0] prev_data = '0;
        logic [PKT_W-1:0] exp_pkt;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_last    = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (bus.rf_rd_en) begin
                    check("credit", 64'((rd_cnt - hs_cnt - disc_cnt) < int'(FIFO_DEPTH)), 64'(1));
                    check("rd_in_range", 64'(rd_idx < run_n), 64'(1));
                    check("rd_addr", 64'(bus.rf_rd_addr), 64'(rd_idx[ACT_NO_W-1:0]));
                    check("rd_bank", 64'(bus.rf_rd_bank), 64'(run_bank));
                    if (chk_b2b) check("rd_cycle", 64'(cyc - start_cyc), 64'(1 + rd_idx));
                end
                if (rd_last && (bus.rf_rd_data == '0)) begin
                    disc_cnt++;
                    last_evt = cyc;
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.bc_valid), 64'(1));
                    check("stall_data", 64'(bus.bc_data), 64'(prev_data));
                end
                if (bus.bc_valid && first_valid < 0) first_valid = cyc;
                if (bus.bc_valid && bus.bc_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("pkt_unexpected", $sformatf("%0h, required no packet", bus.bc_data));
                    end else begin
                        exp_pkt = exp_q.pop_front();
                        check("pkt", 64'(bus.bc_data), 64'(exp_pkt));
                    end
                    hs_cnt++;
                    last_evt = cyc;
                end
                if (fin_broadcast) begin
                    fin_cnt++;
                    fin_cyc = cyc;
                end
                prev_stall = bus.bc_valid && !bus.bc_ready;
                prev_data  = bus.bc_data;
                rd_last    = bus.rf_rd_en;
                if (bus.rf_rd_en) begin
                    if (first_rd < 0) first_rd = cyc;
                    rd_cnt++;
                    rd_idx++;
                end
            end
        end
    end

    // mode 0: random nonzero, 1: random with ~25% zeros, 2: all zero.
    task automatic fill(input int bank, input int mode);
        logic [DATA_W-1:0] v;
        for (int a = 0; a < int'(NENT); a++) begin
            v = DATA_W'($urandom);
            if (v == '0) v = 1;
            if (mode == 1 && $urandom_range(0, 3) == 0) v = '0;
            if (mode == 2) v = '0;
            rf_mem[bank][a] = v;
        end
    endtask

    // Build the expected packet list from the spec rules, then pulse start.
    task automatic begin_run(input int n, input logic bank);
        logic [DATA_W-1:0] v;
        exp_q.delete();
        run_n = n;  run_bank = bank;
        rd_idx = 0; rd_cnt = 0; hs_cnt = 0; disc_cnt = 0;
        fin_cnt = 0; fin_cyc = -1; first_rd = -1; first_valid = -1;
        for (int a = 0; a < n; a++) begin
            v = rf_mem[bank][a];
            if (v != '0) exp_q.push_back({a[ACT_NO_W-1:0], pe_idx, v});
        end
        @(posedge clk);
        #1;
        start_cyc       = cyc;
        last_evt        = cyc;
        start_broadcast = 1'b1;
        in_act_no       = (ACT_NO_W+1)'(n);
        act_regfile_dir = bank;
        @(posedge clk);
        #1;
        start_broadcast = 1'b0;
        in_act_no       = (ACT_NO_W+1)'($urandom);
        act_regfile_dir = 1'($urandom);
    endtask

    task automatic wait_fin(input int budget);
        int t = 0;
        while (fin_cnt == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (fin_cnt == 0) fail("fin_timeout", "no fin_broadcast within budget");
        repeat (4) @(posedge clk);
        #1;
        check("fin_count", 64'(fin_cnt), 64'(1));
        check("all_delivered", 64'(exp_q.size()), 64'(0));
        check("fin_timing", 64'(fin_cyc - last_evt), 64'(2));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},    64'(bus.rf_rd_en),   64'(0));
        check({tag, "_rd_bank"},  64'(bus.rf_rd_bank), 64'(0));
        check({tag, "_rd_addr"},  64'(bus.rf_rd_addr), 64'(0));
        check({tag, "_bc_valid"}, 64'(bus.bc_valid),   64'(0));
        check({tag, "_bc_data"},  64'(bus.bc_data),    64'(0));
        check({tag, "_busy"},     64'(busy),           64'(0));
        check({tag, "_fin"},      64'(fin_broadcast),  64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        pe_idx = 6'd5;
        start_broadcast = 1'b0;
        in_act_no = '0;
        act_regfile_dir = 1'b0;
        fill(0, 0);
        fill(1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Directed: bank 1 = {3,0,7,9}, PE 5, always ready.
        rf_mem[1][0] = 16'd3;
        rf_mem[1][1] = 16'd0;
        rf_mem[1][2] = 16'd7;
        rf_mem[1][3] = 16'd9;
        rdy_mode = 0;
        chk_b2b  = 1'b1;
        begin_run(4, 1'b1);
        check("busy_run", 64'(busy), 64'(1));
        wait_fin(200);
        chk_b2b = 1'b0;
        check("first_rd_lat", 64'(first_rd - start_cyc), 64'(1));
        check("first_valid_lat", 64'(first_valid - start_cyc), 64'(3));
        check("directed_pkts", 64'(hs_cnt), 64'(3));

        // Empty run.
        begin_run(0, 1'b0);
        wait_fin(50);
        check("empty_fin_cycle", 64'(fin_cyc - start_cyc), 64'(2));
        check("empty_no_rd", 64'(first_rd), 64'(-1));
        check("empty_no_valid", 64'(first_valid), 64'(-1));

        // All-zero data: reads issue, nothing is sent.
        fill(0, 2);
        begin_run(8, 1'b0);
        wait_fin(100);
        check("zero_reads", 64'(rd_cnt), 64'(8));
        check("zero_no_valid", 64'(first_valid), 64'(-1));

        // Full 64 entries under random backpressure.
        fill(0, 0);
        rdy_mode = 1;
        begin_run(64, 1'b0);
        wait_fin(2000);
        check("full_pkts", 64'(hs_cnt), 64'(64));

        // Stalled network: only FIFO_DEPTH reads go out until ready rises.
        fill(1, 0);
        rdy_mode = 2;
        begin_run(10, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", 64'(rd_cnt), 64'(FIFO_DEPTH));
        check("stall_no_hs", 64'(hs_cnt), 64'(0));
        check("stall_valid_held", 64'(bus.bc_valid), 64'(1));
        rdy_mode = 0;
        wait_fin(200);
        check("stall_pkts", 64'(hs_cnt), 64'(10));

        // Restart attempt mid-run is ignored.
        fill(0, 1);
        rdy_mode = 1;
        begin_run(20, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        start_broadcast = 1'b1;
        in_act_no       = 7'd40;
        act_regfile_dir = 1'b1;
        @(posedge clk);
        #1;
        start_broadcast = 1'b0;
        wait_fin(1000);
        check("repulse_reads", 64'(rd_cnt), 64'(20));

        // Start landing on the fin cycle is ignored.
        rdy_mode = 0;
        begin_run(3, 1'b1);
        t = 0;
        while (!fin_broadcast && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!fin_broadcast) fail("fincyc_timeout", "no fin_broadcast within budget");
        start_broadcast = 1'b1;
        in_act_no       = 7'd5;
        @(posedge clk);
        #1;
        start_broadcast = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("fincyc_busy", 64'(busy), 64'(0));
        check("fincyc_fin_count", 64'(fin_cnt), 64'(1));
        check("fincyc_reads", 64'(rd_cnt), 64'(3));

        // Asynchronous reset mid-stream, then a clean full broadcast.
        fill(0, 0);
        rdy_mode = 1;
        begin_run(64, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        fin_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_fin", 64'(fin_cnt), 64'(0));
        check("midrst_idle", 64'(busy), 64'(0));
        fill(1, 0);
        begin_run(64, 1'b1);
        wait_fin(2000);
        check("post_rst_pkts", 64'(hs_cnt), 64'(64));

        // Random runs.
        for (int r = 0; r < 5; r++) begin
            logic b;
            int   n;
            b = 1'($urandom);
            n = int'($urandom_range(0, NENT));
            pe_idx = PE_IDX_W'($urandom);
            fill(int'(b), 1);
            rdy_mode = int'($urandom_range(0, 1));
            begin_run(n, b);
            wait_fin(2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
